pool_engine_param: RTL and testbench
====================================

Name: pool_engine_param

Overview:
- Parametrised, sequential 2x2 / stride-2 pooling engine. It is the next-generation pooling stage between the conv array and the downstream FC/flatten stage.
- Accepts one full multi-channel feature map per job. It walks the output windows one per cycle, all channels in parallel.
- Supports a runtime max/average mode and signed or unsigned data.
- Output map is double-buffered, so the published result stays stable while the next job runs.

Parameters:
IN_H, 6, input map height; must be even, >=2
IN_W, 6, input map width; must be even, >=2
CH, 3, channel count, >=1
DATA_W, 8, element width in bits, >=2
SIGNED, 0, 1 = two's-complement compare/average, 0 = unsigned

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  feature map valid; accepted when in_vld & in_rdy at a rising edge
mode  in  1  0 = max, 1 = average; sampled with the accepted map
fmap_lin  in  IN_H*IN_W*CH*DATA_W  input map; channel c at [c*IN_H*IN_W*DATA_W +: IN_H*IN_W*DATA_W]; pixel (r,k) at index r*IN_W+k, bits [idx*DATA_W +: DATA_W]
in_rdy  out  1  high only in IDLE
busy  out  1  high in RUN and DONE
pool_lin  out  (IN_H/2)*(IN_W/2)*CH*DATA_W  output map, same packing with OH=IN_H/2, OW=IN_W/2
out_vld  out  1  one-cycle pulse; pool_lin holds the new result from this cycle on

Behaviour:
- Reset (async, rst_n=0): state=IDLE, window counter=0, work buffer=0, pool_lin=0, out_vld=0, in_rdy=1, busy=0.
- Let N = OH*OW.
- States:
  - IDLE: on accept at edge E0, latch fmap_lin and mode into internal registers, set cnt=0, go to RUN.
  - RUN: at each edge E1..EN, compute window cnt for every channel and write it into the work buffer at index cnt, then increment cnt. At EN (cnt==N-1) go to DONE instead of incrementing.
  - DONE: at edge EN+1, copy the work buffer to pool_lin, register out_vld=1, go to IDLE.
- Latency: out_vld is high in the cycle following edge EN+1, i.e. N+1 edges after accept. Default config: N=9, so 10 edges.
- Window cnt maps to row r = cnt / OW and column k = cnt % OW. Its four inputs are pixels (2r,2k), (2r,2k+1), (2r+1,2k), (2r+1,2k+1).
- Max mode: output is the largest of the four inputs, compared signed when SIGNED=1.
- Average mode:
  - Sum the four inputs in DATA_W+2 bits, sign-extended when SIGNED=1.
  - Result = (sum + 2) shifted right by 2: arithmetic shift when SIGNED=1, logical otherwise (round half up).
  - Truncate to DATA_W; this never overflows.
- The counter wraps to 0 only via the IDLE→RUN transition. It never exceeds N-1.
- in_vld while busy: ignored. No latch, no error, and the current job is unaffected.
- Changes on fmap_lin or mode during RUN have no effect, because the latched copies are used.
- Back-to-back jobs: in_rdy is high in the same cycle as out_vld, so a new accept can coincide with the out_vld cycle. pool_lin then holds the previous result until the new job's DONE.
- Reset mid-job: the job is aborted, outputs return to reset values, and no out_vld pulse is generated.
- Any parameter set with IN_H or IN_W odd must cause a compile-time error (generate-time $error or equivalent).

Test Plan:
- Max, default config, unsigned. Every channel pixel idx has value idx; mode=0; pulse in_vld. Required: out_vld exactly 10 edges after accept; output window 0 = 7, window 4 = 21, window 8 = 35 in all channels; in_rdy=0 and busy=1 for the 10-cycle interval.
- Average rounding, unsigned. Window 0 of channel 1 = {1,2,2,2}, mode=1. Required: sum 7, (7+2)>>2 = 2. Window {255,255,255,255} must give 255, with no wrap.
- Signed. SIGNED=1, window {-1,-1,-1,-2} (0xFF,0xFF,0xFF,0xFE).
  - Average required: (-5+2)>>>2 = -1 (0xFF).
  - Max of {-128,-3,-7,-100} required: -3 (0xFD), not 0x80.
- Busy protection: start job A; assert in_vld with different data and mode=1 at edges E3 and E5. Required: job A result unchanged; exactly one out_vld pulse; in_rdy low during both attempts.
- Back-to-back and hold: accept job B in the out_vld cycle of job A. Required: pool_lin keeps A's value through B's RUN and updates only at B's DONE; second out_vld arrives 10 edges after B's accept.
- Reset mid-job: assert rst_n=0 asynchronously at E4, mid-cycle. Required: pool_lin=0, out_vld=0, in_rdy=1 immediately. No out_vld pulse after release. A fresh job afterwards completes normally.
- Non-default config: IN_H=8, IN_W=4, CH=2, DATA_W=16. Required: N=8 and out_vld 9 edges after accept; max of window 7 on the ramp = idx (7,3) = 31.

Source files
------------

// File: rtl/pool_engine_param_if.sv
// Job handshake and map buses of the pooling engine.
// The master drives the job; the slave is the engine.
interface pool_engine_param_if #(
    parameter int IN_H   = 6,
    parameter int IN_W   = 6,
    parameter int CH     = 3,
    parameter int DATA_W = 8
);
    localparam int IN_BITS  = IN_H * IN_W * CH * DATA_W;
    localparam int OUT_BITS = (IN_H / 2) * (IN_W / 2) * CH * DATA_W;

    logic                in_vld;
    logic                mode;
    logic [IN_BITS-1:0]  fmap_lin;
    logic                in_rdy;
    logic                busy;
    logic [OUT_BITS-1:0] pool_lin;
    logic                out_vld;

    modport master (
        output in_vld, mode, fmap_lin,
        input  in_rdy, busy, pool_lin, out_vld
    );

    modport slave (
        input  in_vld, mode, fmap_lin,
        output in_rdy, busy, pool_lin, out_vld
    );
endinterface

// File: rtl/pool_engine_param.sv
// Sequential 2x2 / stride-2 max/average pooling engine.
// Walks one output window per cycle across all channels and publishes a double-buffered result.
module pool_engine_param #(
    parameter int IN_H   = 6,
    parameter int IN_W   = 6,
    parameter int CH     = 3,
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    pool_engine_param_if.slave bus
);
    localparam int OH       = IN_H / 2;
    localparam int OW       = IN_W / 2;
    localparam int N        = OH * OW;
    localparam int PLANE    = IN_H * IN_W * DATA_W;
    localparam int IN_BITS  = IN_H * IN_W * CH * DATA_W;
    localparam int OUT_BITS = N * CH * DATA_W;
    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W    = (OH > 1) ? $clog2(OH) : 1;
    localparam int COL_W    = (OW > 1) ? $clog2(OW) : 1;

    if ((IN_H % 2) != 0 || (IN_W % 2) != 0 || IN_H < 2 || IN_W < 2) begin : g_bad_geometry
        $error("pool_engine_param: IN_H and IN_W must be even and >= 2");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IN_BITS-1:0]  fmap_q;
    logic                mode_q;
    logic [CNT_W-1:0]    cnt;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [OUT_BITS-1:0] work;
    logic [DATA_W-1:0]   win_res [CH];
    logic                accept;
    logic                last;

    assign accept = (state == IDLE) && bus.in_vld;
    assign last   = (cnt == CNT_W'(N - 1));

    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    function automatic logic [DATA_W+1:0] widen(input logic [DATA_W-1:0] a);
        return {{2{(SIGNED != 0) && a[DATA_W-1]}}, a};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path can infer a latch.
        state_nxt  = state;
        bus.in_rdy = 1'b0;
        bus.busy   = 1'b1;
        case (state)
            IDLE: begin
                bus.in_rdy = 1'b1;
                bus.busy   = 1'b0;
                if (bus.in_vld) state_nxt = RUN;
            end
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the latched map is deliberately not reset; it is only read after a fresh load.
    always_ff @(posedge clk) begin
        if (accept) begin
            fmap_q <= bus.fmap_lin;
            mode_q <= bus.mode;
        end
    end

    // Window (row, col) covers input pixels (2row..2row+1, 2col..2col+1) of every channel.
    always_comb begin : window_calc
        int                base;
        logic [DATA_W-1:0] p0, p1, p2, p3, m01, m23, mx;
        logic [DATA_W+1:0] sum, avg;
        for (int c = 0; c < CH; c++) begin
            base = c * PLANE + (2 * int'(row) * IN_W + 2 * int'(col)) * DATA_W;
            p0   = fmap_q[base +: DATA_W];
            p1   = fmap_q[base + DATA_W +: DATA_W];
            p2   = fmap_q[base + IN_W * DATA_W +: DATA_W];
            p3   = fmap_q[base + (IN_W + 1) * DATA_W +: DATA_W];
            m01  = greater(p1, p0) ? p1 : p0;
            m23  = greater(p3, p2) ? p3 : p2;
            mx   = greater(m23, m01) ? m23 : m01;
            // Round half up: the +2 bias before the divide-by-4 cannot overflow DATA_W+2 bits.
            sum  = widen(p0) + widen(p1) + widen(p2) + widen(p3) + (DATA_W + 2)'(2);
            if (SIGNED != 0) avg = $signed(sum) >>> 2;
            else             avg = sum >> 2;
            win_res[c] = mode_q ? avg[DATA_W-1:0] : mx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            row          <= '0;
            col          <= '0;
            work         <= '0;
            bus.pool_lin <= '0;
            bus.out_vld  <= 1'b0;
        end else begin
            bus.out_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_vld) begin
                        cnt <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                RUN: begin
                    for (int c = 0; c < CH; c++)
                        work[c * N * DATA_W + int'(cnt) * DATA_W +: DATA_W] <= win_res[c];
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                        if (col == COL_W'(OW - 1)) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.pool_lin <= work;
                    bus.out_vld  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_engine_param.sv
// Scoreboard bench for pool_engine_param: unsigned 6x6x3, signed 6x6x3 and 8x4x2 16-bit instances.
// The driver queues expected windows per job; a monitor checks them on every out_vld pulse.
module tb_pool_engine_param;
    localparam int FW0 = 6 * 6 * 3 * 8;
    localparam int FW2 = 8 * 4 * 2 * 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_engine_param_if #(.IN_H(6), .IN_W(6), .CH(3), .DATA_W(8))  b0 ();
    pool_engine_param_if #(.IN_H(6), .IN_W(6), .CH(3), .DATA_W(8))  b1 ();
    pool_engine_param_if #(.IN_H(8), .IN_W(4), .CH(2), .DATA_W(16)) b2 ();

    pool_engine_param #(.IN_H(6), .IN_W(6), .CH(3), .DATA_W(8), .SIGNED(0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pool_engine_param #(.IN_H(6), .IN_W(6), .CH(3), .DATA_W(8), .SIGNED(1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pool_engine_param #(.IN_H(8), .IN_W(4), .CH(2), .DATA_W(16), .SIGNED(0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {int dut; int acc; int lat; int nchk;} job_t;
    typedef struct {int ch; int win; int val;} exp_t;

    job_t jobq[$];
    exp_t expq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hw_of(int d); return (d == 2) ? 32 : 36; endfunction
    function automatic int dw_of(int d); return (d == 2) ? 16 : 8;  endfunction
    function automatic int n_of(int d);  return (d == 2) ? 8 : 9;   endfunction
    function automatic int ch_of(int d); return (d == 2) ? 2 : 3;   endfunction

    function automatic logic [1023:0] put(logic [1023:0] v, int plane, int dw, int c, int idx, int val);
        logic [1023:0] r = v;
        for (int b = 0; b < dw; b++) r[(c * plane + idx) * dw + b] = val[b];
        return r;
    endfunction

    function automatic int get(logic [255:0] p, int plane, int dw, int c, int idx);
        int r = 0;
        for (int b = 0; b < dw; b++) r[b] = p[(c * plane + idx) * dw + b];
        return r;
    endfunction

    function automatic logic [1023:0] ramp(int d);
        logic [1023:0] v = '0;
        for (int c = 0; c < ch_of(d); c++)
            for (int i = 0; i < hw_of(d); i++) v = put(v, hw_of(d), dw_of(d), c, i, i);
        return v;
    endfunction

    function automatic int rdy(int d);
        case (d)
            0:       return int'(b0.in_rdy);
            1:       return int'(b1.in_rdy);
            default: return int'(b2.in_rdy);
        endcase
    endfunction

    function automatic int bsy(int d);
        case (d)
            0:       return int'(b0.busy);
            1:       return int'(b1.busy);
            default: return int'(b2.busy);
        endcase
    endfunction

    function automatic int ovld(int d);
        case (d)
            0:       return int'(b0.out_vld);
            1:       return int'(b1.out_vld);
            default: return int'(b2.out_vld);
        endcase
    endfunction

    function automatic logic [255:0] pool(int d);
        case (d)
            0:       return 256'(b0.pool_lin);
            1:       return 256'(b1.pool_lin);
            default: return 256'(b2.pool_lin);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic want(int c, int w, int v);
        expq.push_back('{c, w, v});
    endtask

    task automatic drive(int d, logic v, logic m, logic [1023:0] f);
        case (d)
            0: begin b0.in_vld = v; b0.mode = m; b0.fmap_lin = f[FW0-1:0]; end
            1: begin b1.in_vld = v; b1.mode = m; b1.fmap_lin = f[FW0-1:0]; end
            default: begin b2.in_vld = v; b2.mode = m; b2.fmap_lin = f[FW2-1:0]; end
        endcase
    endtask

    // Called at a negedge; returns 1 ns after the accepting edge.
    task automatic start(int d, logic m, logic [1023:0] f, int nchk, bit track);
        int t = 0;
        while (rdy(d) == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("u%0d_start_in_rdy", d), rdy(d), 1);
        drive(d, 1'b1, m, f);
        @(posedge clk);
        #1;
        drive(d, 1'b0, m, f);
        if (track) jobq.push_back('{d, cyc, n_of(d) + 1, nchk});
    endtask

    task automatic wait_done();
        for (int t = 0; t < 60 && jobq.size() != 0; t++) @(negedge clk);
        check("job_drain", jobq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic score(int d, logic [255:0] p);
        job_t j;
        exp_t e;
        check($sformatf("u%0d_out_vld_expected", d), int'(jobq.size() > 0), 1);
        if (jobq.size() == 0) return;
        j = jobq.pop_front();
        check("out_vld_instance", d, j.dut);
        check($sformatf("u%0d_latency", d), cyc - j.acc, j.lat);
        for (int i = 0; i < j.nchk; i++) begin
            e = expq.pop_front();
            check($sformatf("u%0d_c%0d_w%0d", d, e.ch, e.win),
                  get(p, n_of(d), dw_of(d), e.ch, e.win), e.val);
        end
    endtask

    always @(negedge clk) begin
        if (b0.out_vld) score(0, pool(0));
        if (b1.out_vld) score(1, pool(1));
        if (b2.out_vld) score(2, pool(2));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] ramp0, ramp2, avg0, junk, sgn_avg, sgn_max;
        int t;
        ramp0 = ramp(0);
        ramp2 = ramp(2);
        junk  = {128{8'hAA}};

        // Unsigned average vectors: rounding, saturation-free 255, small sums.
        avg0 = '0;
        for (int i = 0; i < 4; i++) avg0 = put(avg0, 36, 8, 0, (i < 2) ? i : i + 4, 255);
        avg0 = put(avg0, 36, 8, 1, 0, 1);
        avg0 = put(avg0, 36, 8, 1, 1, 2);
        avg0 = put(avg0, 36, 8, 1, 6, 2);
        avg0 = put(avg0, 36, 8, 1, 7, 2);
        avg0 = put(avg0, 36, 8, 2, 0, 1);
        avg0 = put(avg0, 36, 8, 2, 14, 2);
        avg0 = put(avg0, 36, 8, 2, 15, 2);
        avg0 = put(avg0, 36, 8, 2, 20, 2);

        sgn_avg = '0;
        sgn_avg = put(sgn_avg, 36, 8, 0, 0, 'hFF);
        sgn_avg = put(sgn_avg, 36, 8, 0, 1, 'hFF);
        sgn_avg = put(sgn_avg, 36, 8, 0, 6, 'hFF);
        sgn_avg = put(sgn_avg, 36, 8, 0, 7, 'hFE);
        for (int i = 0; i < 4; i++) begin
            sgn_avg = put(sgn_avg, 36, 8, 1, (i < 2) ? i : i + 4, 'h80);
            sgn_avg = put(sgn_avg, 36, 8, 2, (i < 2) ? i : i + 4, 'h7F);
            sgn_avg = put(sgn_avg, 36, 8, 1, (i < 2) ? i + 2 : i + 6, (i == 3) ? 'hFF : 'hFE);
        end

        sgn_max = '0;
        sgn_max = put(sgn_max, 36, 8, 0, 0, 'h80);
        sgn_max = put(sgn_max, 36, 8, 0, 1, 'hFD);
        sgn_max = put(sgn_max, 36, 8, 0, 6, 'hF9);
        sgn_max = put(sgn_max, 36, 8, 0, 7, 'h9C);
        sgn_max = put(sgn_max, 36, 8, 1, 0, 'h01);
        sgn_max = put(sgn_max, 36, 8, 1, 1, 'hFF);
        sgn_max = put(sgn_max, 36, 8, 1, 6, 'h80);
        sgn_max = put(sgn_max, 36, 8, 2, 0, 'hFE);
        sgn_max = put(sgn_max, 36, 8, 2, 1, 'hFF);
        sgn_max = put(sgn_max, 36, 8, 2, 6, 'h81);
        sgn_max = put(sgn_max, 36, 8, 2, 7, 'hFE);
        sgn_max = put(sgn_max, 36, 8, 2, 5, 'h80);
        sgn_max = put(sgn_max, 36, 8, 2, 10, 'hFF);
        sgn_max = put(sgn_max, 36, 8, 2, 11, 'hFF);

        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, '0);
        #12;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("u%0d_rst_in_rdy", d), rdy(d), 1);
            check($sformatf("u%0d_rst_busy", d), bsy(d), 0);
            check($sformatf("u%0d_rst_out_vld", d), ovld(d), 0);
            check($sformatf("u%0d_rst_pool_zero", d), int'(pool(d) === '0), 1);
        end
        @(negedge clk) rst_n = 1'b1;

        // Unsigned max on the ramp, with in_rdy/busy watched over the whole job.
        for (int c = 0; c < 3; c++) begin want(c, 0, 7); want(c, 4, 21); want(c, 8, 35); end
        @(negedge clk);
        start(0, 1'b0, ramp0, 9, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("run_in_rdy", rdy(0), 0);
            check("run_busy", bsy(0), 1);
        end
        @(negedge clk);
        check("done_in_rdy", rdy(0), 1);
        wait_done();

        // Unsigned average.
        want(0, 0, 255); want(1, 0, 2); want(2, 0, 0); want(2, 4, 2); want(0, 4, 0);
        @(negedge clk);
        start(0, 1'b1, avg0, 5, 1'b1);
        wait_done();

        // In_vld with other data and mode while busy is ignored.
        for (int c = 0; c < 3; c++) begin want(c, 0, 7); want(c, 4, 21); want(c, 8, 35); end
        @(negedge clk);
        start(0, 1'b0, ramp0, 9, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 3 || i == 5) begin
                drive(0, 1'b1, 1'b1, junk);
                check("busy_in_rdy", rdy(0), 0);
            end else begin
                drive(0, 1'b0, 1'b0, junk);
            end
        end
        wait_done();

        // Back-to-back: job B accepted in job A's out_vld cycle; pool_lin holds A until B is done.
        for (int c = 0; c < 3; c++) begin want(c, 0, 7); want(c, 4, 21); want(c, 8, 35); end
        @(negedge clk);
        start(0, 1'b0, ramp0, 9, 1'b1);
        t = 0;
        while (ovld(0) == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_out_vld", ovld(0), 1);
        want(0, 0, 255); want(1, 0, 2); want(2, 0, 0); want(2, 4, 2); want(0, 4, 0);
        start(0, 1'b1, avg0, 5, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b2b_hold_c0_w4", get(pool(0), 9, 8, 0, 4), 21);
            check("b2b_hold_c1_w8", get(pool(0), 9, 8, 1, 8), 35);
        end
        wait_done();

        // Asynchronous reset mid-job aborts it without any out_vld.
        @(negedge clk);
        start(0, 1'b0, ramp0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_pool_zero", int'(pool(0) === '0), 1);
        check("midrst_out_vld", ovld(0), 0);
        check("midrst_in_rdy", rdy(0), 1);
        check("midrst_busy", bsy(0), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(negedge clk);
        want(0, 0, 7); want(2, 8, 35);
        start(0, 1'b0, ramp0, 2, 1'b1);
        wait_done();

        // Signed average and max.
        want(0, 0, 'hFF); want(1, 0, 'h80); want(2, 0, 'h7F); want(1, 1, 'hFE); want(0, 8, 0);
        @(negedge clk);
        start(1, 1'b1, sgn_avg, 5, 1'b1);
        wait_done();
        want(0, 0, 'hFD); want(1, 0, 'h01); want(2, 2, 'h00); want(2, 0, 'hFF);
        @(negedge clk);
        start(1, 1'b0, sgn_max, 4, 1'b1);
        wait_done();

        // 8x4x2 16-bit instance: N=8, max and average on the ramp.
        for (int c = 0; c < 2; c++) begin want(c, 0, 5); want(c, 3, 15); want(c, 7, 31); end
        @(negedge clk);
        start(2, 1'b0, ramp2, 6, 1'b1);
        wait_done();
        for (int c = 0; c < 2; c++) begin want(c, 0, 3); want(c, 3, 13); want(c, 7, 29); end
        @(negedge clk);
        start(2, 1'b1, ramp2, 6, 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
